axi_mem_arbiter: RTL and testbench
==================================

Name: axi_mem_arbiter

Overview:
- Shares the single AXI4 memory port between the instruction cache (master M0, read-only) and the data cache (master M1, read plus write-back).
- Serialises read bursts; each grant is held until the burst's last beat.
- Write channels pass straight through from M1.
- Tracks outstanding write-backs so a data-cache line refill never overtakes its own write-back.
- Sits between the two caches and the memory/crossbar slave.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width; strobe width DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_araddr/m0_arlen/m0_arsize/m0_arburst  in  ADDR_W/8/3/2  M0 read address
m0_arvalid  in  1;  m0_arready  out  1
m0_rdata  out  DATA_W;  m0_rresp  out  2;  m0_rvalid  out  1;  m0_rlast  out  1;  m0_rready  in  1
m1_araddr/m1_arlen/m1_arsize/m1_arburst  in  ADDR_W/8/3/2;  m1_arvalid  in  1;  m1_arready  out  1
m1_rdata  out  DATA_W;  m1_rresp  out  2;  m1_rvalid  out  1;  m1_rlast  out  1;  m1_rready  in  1
m1_awaddr/m1_awlen/m1_awburst  in  ADDR_W/8/2;  m1_awvalid  in  1;  m1_awready  out  1
m1_wdata/m1_wstrb  in  DATA_W/DATA_W/8;  m1_wlast, m1_wvalid  in  1;  m1_wready  out  1
m1_bresp  out  2;  m1_bvalid  out  1;  m1_bready  in  1
s_ar*/s_r*/s_aw*/s_w*/s_b*  mirror of the above toward the slave, opposite directions

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: state=R_IDLE, grant=0, wr_pending=0.
- Reset output values: s_arvalid=0, m0_arready=0, m1_arready=0, m0_rvalid=0, m1_rvalid=0, s_rready=0.
- Write-path outputs are pure pass-through, so they follow their inputs at reset.
- A rst asserted mid-burst aborts immediately to R_IDLE. The slave must be reset at the same time.
- Read FSM, R_IDLE: a request is eligible if m0_arvalid, or (m1_arvalid and not wr_pending).
  - Any eligible request: latch the grant and the winner's araddr/arlen/arsize/arburst into registers, go to R_ADDR.
  - Fixed priority: M1 beats M0.
- Read FSM, R_ADDR:
  - s_arvalid=1, driven from the latched registers.
  - The granted master's arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready, go to R_DATA.
- Read FSM, R_DATA:
  - s_r* is routed to the granted master; s_rready = granted master's rready.
  - The non-granted master sees rvalid=0.
  - On s_rvalid & s_rready & s_rlast, go to R_IDLE.
- Latency:
  - Request visible to the slave one cycle after arvalid is sampled in R_IDLE.
  - At least one R_IDLE cycle between bursts.
- rresp is forwarded unmodified, including SLVERR/DECERR. An error does not end the burst early; only rlast does.
- s_rvalid seen outside R_DATA: s_rready=0; the beat is not consumed.
- Write path: M1 aw/w/b are combinational pass-through to s_aw/s_w/s_b.
- wr_pending:
  - Set on s_awvalid & s_awready.
  - Cleared on s_bvalid & s_bready.
  - If set and clear occur in the same cycle, it stays set (a new write was accepted).
- An M1 read arriving while wr_pending=1 waits in R_IDLE. M0 may be granted meanwhile.

Optional Feature:
- Macro: AXI_ARB_ROUND_ROBIN_EN.
- Defined: a last_grant register (reset 0) records the master granted most recently. On simultaneous eligible requests, the master not equal to last_grant wins.
- Undefined: fixed M1-over-M0 priority; no last_grant register.

Decomposition:
- Shared package axi_pkg holds:
  - burst constants BURST_FIXED/INCR/WRAP;
  - resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - the read-state encoding R_IDLE=0, R_ADDR=1, R_DATA=2.
- One natural sub-module: arb_pick.
  - Combinational 2-way winner selection from the eligible requests plus last_grant.
  - Lets the priority policy be swapped without touching the FSM.

Test Plan:
- M0 alone reads 0x8000_0040 with arlen=7: s_araddr=0x8000_0040 one cycle later; 8 beats reach M0 only; m1_rvalid stays 0; R_IDLE after rlast.
- M0 and M1 arvalid in the same cycle: M1 is granted first; M0 is granted after M1's rlast plus one idle cycle. With the macro defined and last_grant=M1, M0 wins instead.
- M1 write-back to 0x8000_1000, then M1 read of the same line before bvalid: the read is stalled until the s_b handshake; s_arvalid rises the cycle after wr_pending clears.
- M0 read during an outstanding M1 write: the M0 grant proceeds without waiting for bvalid.
- Slave returns rresp=SLVERR on beat 3 with s_rready throttled by M1 rready=0 on beats 2 and 5: no beat lost or duplicated; resp forwarded; burst ends only on rlast.
- rst asserted during R_DATA beat 4: next cycle state=R_IDLE, s_arvalid=0, both arready=0, wr_pending=0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-arbiter state encoding used by axi_mem_arbiter.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

endpackage

// File: rtl/arb_pick.sv
// Two-way read winner selection (pick=1 means M1).
// Round-robin tie-break when AXI_ARB_ROUND_ROBIN_EN is defined, else fixed M1 priority.
module arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic pick
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) pick = ~last_grant;
        else              pick = req1;
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        valid = req0 | req1;
        pick  = req1;
    end
`endif

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 memory port between the I-cache (M0, read) and D-cache (M1, read + write-back).
// Optional round-robin tie-break via AXI_ARB_ROUND_ROBIN_EN.
//
// state  | meaning
// R_IDLE | no read in flight; pick a winner among eligible requests
// R_ADDR | latched AR presented to slave, waiting for s_arready
// R_DATA | R beats routed to the granted master until rlast
module axi_mem_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rvalid,
    output logic                m0_rlast,
    input  logic                m0_rready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rvalid,
    output logic                m1_rlast,
    input  logic                m1_rready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    output logic [1:0]          m1_bresp,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    input  logic                s_rlast,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [1:0]          s_awburst,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    r_state_e state;
    logic     grant;
    logic     wr_pending;
    logic     last_grant;
    logic     req0, req1, pick_valid, pick;

    // An M1 refill must not overtake its own outstanding write-back.
    assign req0 = m0_arvalid;
    assign req1 = m1_arvalid & ~wr_pending;

    arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .pick       (pick)
    );

`ifdef AXI_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)                                   last_grant <= 1'b0;
        else if (state == R_IDLE && pick_valid)    last_grant <= pick;
    end
`else
    assign last_grant = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= R_IDLE;
            grant     <= 1'b0;
            s_arvalid <= 1'b0;
            s_araddr  <= '0;
            s_arlen   <= '0;
            s_arsize  <= '0;
            s_arburst <= '0;
        end else begin
            case (state)
                R_IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick;
                        s_araddr  <= pick ? m1_araddr  : m0_araddr;
                        s_arlen   <= pick ? m1_arlen   : m0_arlen;
                        s_arsize  <= pick ? m1_arsize  : m0_arsize;
                        s_arburst <= pick ? m1_arburst : m0_arburst;
                        s_arvalid <= 1'b1;
                        state     <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (s_arready) begin
                        s_arvalid <= 1'b0;
                        state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) state <= R_IDLE;
                end
                default: begin
                    s_arvalid <= 1'b0;
                    state     <= R_IDLE;
                end
            endcase
        end
    end

    // A new accept wins over a same-cycle completion.
    always_ff @(posedge clk) begin
        if (rst)                          wr_pending <= 1'b0;
        else if (s_awvalid && s_awready)  wr_pending <= 1'b1;
        else if (s_bvalid && s_bready)    wr_pending <= 1'b0;
    end

    logic in_addr, in_data;
    assign in_addr = (state == R_ADDR);
    assign in_data = (state == R_DATA);

    assign m0_arready = in_addr & ~grant & s_arready;
    assign m1_arready = in_addr &  grant & s_arready;

    assign s_rready  = in_data & (grant ? m1_rready : m0_rready);
    assign m0_rvalid = in_data & ~grant & s_rvalid;
    assign m1_rvalid = in_data &  grant & s_rvalid;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;

    assign s_awaddr   = m1_awaddr;
    assign s_awlen    = m1_awlen;
    assign s_awburst  = m1_awburst;
    assign s_awvalid  = m1_awvalid;
    assign m1_awready = s_awready;
    assign s_wdata    = m1_wdata;
    assign s_wstrb    = m1_wstrb;
    assign s_wlast    = m1_wlast;
    assign s_wvalid   = m1_wvalid;
    assign m1_wready  = s_wready;
    assign m1_bresp   = s_bresp;
    assign m1_bvalid  = s_bvalid;
    assign s_bready   = m1_bready;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed self-checking bench for axi_mem_arbiter; the bench acts as both caches and the slave.
module tb_axi_mem_arbiter;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, s_araddr, s_awaddr;
    logic [7:0]  m0_arlen, m1_arlen, m1_awlen, s_arlen, s_awlen;
    logic [2:0]  m0_arsize, m1_arsize, s_arsize;
    logic [1:0]  m0_arburst, m1_arburst, m1_awburst, s_arburst, s_awburst;
    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [63:0] m0_rdata, m1_rdata, m1_wdata, s_rdata, s_wdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_rresp, s_bresp;
    logic        m0_rvalid, m0_rlast, m0_rready, m1_rvalid, m1_rlast, m1_rready;
    logic        m1_awvalid, m1_awready, m1_wlast, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [7:0]  m1_wstrb, s_wstrb;
    logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    int nvec = 0;
    int nerr = 0;

    axi_mem_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address phase: request from R_IDLE through the AR handshake into R_DATA.
    task automatic start_read(input logic who, input logic [31:0] addr, input logic [7:0] len);
        if (who) begin
            m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd3; m1_arburst = BURST_INCR; m1_arvalid = 1'b1;
        end else begin
            m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd3; m0_arburst = BURST_INCR; m0_arvalid = 1'b1;
        end
        #1 chk("ar_not_yet", 64'(s_arvalid), 64'd1 - 64'd1);
        tick();
        chk("ar_valid", 64'(s_arvalid), 64'd1);
        chk("ar_addr", 64'(s_araddr), 64'(addr));
        chk("ar_len", 64'(s_arlen), 64'(len));
        s_arready = 1'b1;
        #1 chk("ar_ready_win", 64'(who ? m1_arready : m0_arready), 64'd1);
        chk("ar_ready_lose", 64'(who ? m0_arready : m1_arready), 64'd0);
        tick();
        if (who) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        s_arready = 1'b0;
        #1 chk("ar_drop", 64'(s_arvalid), 64'd0);
    endtask

    task automatic beats(input logic who, input int n, input logic [63:0] base, input logic last);
        for (int i = 0; i < n; i++) begin
            s_rvalid = 1'b1; s_rdata = base + 64'(i); s_rresp = OKAY;
            s_rlast  = last && (i == n - 1);
            #1;
            chk("r_valid", 64'(who ? m1_rvalid : m0_rvalid), 64'd1);
            chk("r_other", 64'(who ? m0_rvalid : m1_rvalid), 64'd0);
            chk("r_data", who ? m1_rdata : m0_rdata, base + 64'(i));
            chk("r_last", 64'(who ? m1_rlast : m0_rlast), 64'(last && (i == n - 1)));
            chk("r_resp", 64'(who ? m1_rresp : m0_rresp), 64'(OKAY));
            chk("s_rready", 64'(s_rready), 64'd1);
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    task automatic run_read(input logic who, input logic [31:0] addr, input logic [7:0] len);
        start_read(who, addr, len);
        beats(who, int'(len) + 1, {32'h0, addr}, 1'b1);
        chk("idle_after", 64'(dut.state), 64'(R_IDLE));
    endtask

    logic exp_m0_first;
    int   b;
    logic stalled;

    initial begin
        rst = 1'b1;
        m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        m1_awaddr = '0; m1_awlen = '0; m1_awburst = '0; m1_awvalid = 1'b0;
        m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;

        // Reset state and outputs
        tick(); tick();
        chk("rst_state", 64'(dut.state), 64'(R_IDLE));
        chk("rst_grant", 64'(dut.grant), 64'd0);
        chk("rst_wrpend", 64'(dut.wr_pending), 64'd0);
        chk("rst_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_m0_arready", 64'(m0_arready), 64'd0);
        chk("rst_m1_arready", 64'(m1_arready), 64'd0);
        chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
        chk("rst_rready", 64'(s_rready), 64'd0);
        m1_awvalid = 1'b1;
        #1 chk("rst_aw_passthru", 64'(s_awvalid), 64'd1);
        m1_awvalid = 1'b0;
        rst = 1'b0;
        tick();

        // M0 alone, 8-beat burst
        run_read(1'b0, 32'h8000_0040, 8'd7);

        // s_rvalid outside R_DATA is not consumed
        s_rvalid = 1'b1;
        #1 chk("stray_rready", 64'(s_rready), 64'd0);
        chk("stray_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("stray_m1_rvalid", 64'(m1_rvalid), 64'd0);
        tick();
        s_rvalid = 1'b0;

        // Simultaneous requests: M1 first, M0 after one idle cycle
        m0_araddr = 32'h1000; m0_arlen = 8'd0; m0_arvalid = 1'b1;
        m1_araddr = 32'h2000; m1_arlen = 8'd1; m1_arvalid = 1'b1;
        tick();
        chk("tie_first_addr", 64'(s_araddr), 64'h2000);
        s_arready = 1'b1;
        #1 chk("tie_m1_arready", 64'(m1_arready), 64'd1);
        chk("tie_m0_arready", 64'(m0_arready), 64'd0);
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        beats(1'b1, 2, 64'h2000, 1'b1);
        chk("tie_idle_gap", 64'(s_arvalid), 64'd0);
        tick();
        chk("tie_second_valid", 64'(s_arvalid), 64'd1);
        chk("tie_second_addr", 64'(s_araddr), 64'h1000);
        s_arready = 1'b1;
        #1 chk("tie_m0_arready2", 64'(m0_arready), 64'd1);
        tick();
        m0_arvalid = 1'b0; s_arready = 1'b0;
        beats(1'b0, 1, 64'h1000, 1'b1);

        // Tie after an M1 grant: round-robin hands it to M0
        run_read(1'b1, 32'h3000, 8'd0);
`ifdef AXI_ARB_ROUND_ROBIN_EN
        exp_m0_first = 1'b1;
`else
        exp_m0_first = 1'b0;
`endif
        m0_araddr = 32'h4000; m0_arlen = 8'd0; m0_arvalid = 1'b1;
        m1_araddr = 32'h5000; m1_arlen = 8'd0; m1_arvalid = 1'b1;
        tick();
        chk("rr_first_addr", 64'(s_araddr), exp_m0_first ? 64'h4000 : 64'h5000);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        if (exp_m0_first) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        beats(~exp_m0_first, 1, exp_m0_first ? 64'h4000 : 64'h5000, 1'b1);
        tick();
        chk("rr_second_addr", 64'(s_araddr), exp_m0_first ? 64'h5000 : 64'h4000);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0; m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        beats(exp_m0_first, 1, exp_m0_first ? 64'h5000 : 64'h4000, 1'b1);

        // Write-back then refill of the same line: refill waits for B
        m1_awaddr = 32'h8000_1000; m1_awlen = 8'd7; m1_awburst = BURST_INCR; m1_awvalid = 1'b1; s_awready = 1'b1;
        #1 chk("aw_addr", 64'(s_awaddr), 64'h8000_1000);
        chk("aw_ready", 64'(m1_awready), 64'd1);
        tick();
        m1_awvalid = 1'b0; s_awready = 1'b0;
        #1 chk("wr_pend_set", 64'(dut.wr_pending), 64'd1);
        m1_wdata = 64'hDEAD_BEEF_0123_4567; m1_wstrb = 8'hF0; m1_wlast = 1'b1; m1_wvalid = 1'b1; s_wready = 1'b1;
        #1 chk("w_data", s_wdata, 64'hDEAD_BEEF_0123_4567);
        chk("w_strb", 64'(s_wstrb), 64'hF0);
        chk("w_ready", 64'(m1_wready), 64'd1);
        tick();
        m1_wvalid = 1'b0; m1_wlast = 1'b0; s_wready = 1'b0;
        m1_araddr = 32'h8000_1000; m1_arlen = 8'd7; m1_arsize = 3'd3; m1_arburst = BURST_INCR; m1_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("refill_stall", 64'(s_arvalid), 64'd0);
        end
        s_bvalid = 1'b1; s_bresp = OKAY; m1_bready = 1'b1;
        #1 chk("b_valid", 64'(m1_bvalid), 64'd1);
        chk("b_ready", 64'(s_bready), 64'd1);
        tick();
        s_bvalid = 1'b0; m1_bready = 1'b0;
        #1 chk("wr_pend_clr", 64'(dut.wr_pending), 64'd0);
        chk("refill_not_yet", 64'(s_arvalid), 64'd0);
        tick();
        chk("refill_go", 64'(s_arvalid), 64'd1);
        chk("refill_addr", 64'(s_araddr), 64'h8000_1000);
        s_arready = 1'b1;
        tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;

        // Throttled refill with SLVERR on beat 3
        b = 0; stalled = 1'b0;
        for (int c = 0; c < 20 && b < 8; c++) begin
            chk("err_in_data", 64'(dut.state), 64'(R_DATA));
            s_rvalid = 1'b1; s_rdata = 64'hA000 + 64'(b);
            s_rresp = (b == 3) ? SLVERR : OKAY; s_rlast = (b == 7);
            m1_rready = !(((b == 2) || (b == 5)) && !stalled);
            #1;
            chk("err_rvalid", 64'(m1_rvalid), 64'd1);
            chk("err_rdata", m1_rdata, 64'hA000 + 64'(b));
            chk("err_rresp", 64'(m1_rresp), (b == 3) ? 64'(SLVERR) : 64'(OKAY));
            chk("err_rlast", 64'(m1_rlast), 64'(b == 7));
            chk("err_rready", 64'(s_rready), 64'(m1_rready));
            tick();
            if (m1_rready) begin b++; stalled = 1'b0; end
            else stalled = 1'b1;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = OKAY; m1_rready = 1'b1;
        chk("err_beats", 64'(b), 64'd8);
        chk("err_idle", 64'(dut.state), 64'(R_IDLE));

        // M0 proceeds during an outstanding write; set wins over same-cycle clear
        m1_awvalid = 1'b1; s_awready = 1'b1;
        tick();
        m1_awvalid = 1'b0; s_awready = 1'b0;
        run_read(1'b0, 32'h6000, 8'd1);
        chk("m0_during_wr", 64'(dut.wr_pending), 64'd1);
        m1_awvalid = 1'b1; s_awready = 1'b1; s_bvalid = 1'b1; m1_bready = 1'b1;
        tick();
        m1_awvalid = 1'b0; s_awready = 1'b0;
        #1 chk("set_clr_same", 64'(dut.wr_pending), 64'd1);
        tick();
        s_bvalid = 1'b0; m1_bready = 1'b0;
        #1 chk("clr_only", 64'(dut.wr_pending), 64'd0);

        // Reset in the middle of a burst (beat 4)
        m1_awvalid = 1'b1; s_awready = 1'b1;
        tick();
        m1_awvalid = 1'b0; s_awready = 1'b0;
        start_read(1'b0, 32'h7000, 8'd7);
        beats(1'b0, 4, 64'h7000, 1'b0);
        s_rvalid = 1'b1; s_rdata = 64'h7004; rst = 1'b1;
        tick();
        chk("mid_rst_state", 64'(dut.state), 64'(R_IDLE));
        chk("mid_rst_arvalid", 64'(s_arvalid), 64'd0);
        chk("mid_rst_m0_arready", 64'(m0_arready), 64'd0);
        chk("mid_rst_m1_arready", 64'(m1_arready), 64'd0);
        chk("mid_rst_wrpend", 64'(dut.wr_pending), 64'd0);
        chk("mid_rst_rvalid", 64'(m0_rvalid), 64'd0);
        chk("mid_rst_rready", 64'(s_rready), 64'd0);
        rst = 1'b0; s_rvalid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
